regfile_wr_arbiter: RTL and testbench

Arbitrates a single register-file write port between two writeback requesters (req0 = ALU writeback, req1 = load writeback). Each accepted write is registered and driven as a one-hot per-register enable plus shared write data. These feed the enable-equipped D flip-flops that form each register. Register ZERO_REG is hardwired zero, so writes to it are accepted but never produce an enable. The block also keeps a saturating count of contention cycles for performance debug.

---
 rtl/regfile_wr_arbiter_if.sv | 29 ++
 rtl/regfile_wr_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bundle: two requesters, each with a valid/ready handshake,
// a destination register address and write data.
interface regfile_wr_arbiter_if #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [WIDTH-1:0]  req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [WIDTH-1:0]  req1_data;
    logic              req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for one register-file write port shared by the ALU and
// load writeback paths, with a registered one-hot enable stage.
module regfile_wr_arbiter #(
    parameter int WIDTH    = 64,
    parameter int NREG     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    regfile_wr_arbiter_if.slave  req,
    output logic [NREG-1:0]      wr_en,
    output logic [WIDTH-1:0]     wr_data,
    output logic                 grant_id,
    output logic [CNT_W-1:0]     conflict_cnt
);
    logic              prio_reg, prio_next;
    logic [NREG-1:0]   wr_en_reg, wr_en_next;
    logic [WIDTH-1:0]  wr_data_reg, wr_data_next;
    logic              grant_id_reg, grant_id_next;
    logic [CNT_W-1:0]  conflict_cnt_reg, conflict_cnt_next;

    logic              active;
    logic              grant0, grant1;
    logic              ready0, ready1;
    logic              xfer;
    logic              contention;
    logic [ADDR_W-1:0] sel_addr;

    always_comb begin
        active     = reset & ~stall;
        // A lone requester always wins; on a tie prio names the winner.
        grant0     = req.req0_valid & (~req.req1_valid | ~prio_reg);
        grant1     = req.req1_valid & (~req.req0_valid | prio_reg);
        ready0     = active & grant0;
        ready1     = active & grant1;
        xfer       = ready0 | ready1;
        contention = active & req.req0_valid & req.req1_valid;
        sel_addr   = ready1 ? req.req1_addr : req.req0_addr;
    end

    assign req.req0_ready = ready0;
    assign req.req1_ready = ready1;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_dec
            // The hardwired-zero register never receives an enable.
            assign wr_en_next[gi] = xfer && (sel_addr == ADDR_W'(gi)) && (gi != ZERO_REG);
        end
    endgenerate

    always_comb begin
        wr_data_next      = wr_data_reg;
        grant_id_next     = grant_id_reg;
        prio_next         = prio_reg;
        conflict_cnt_next = conflict_cnt_reg;
        if (xfer) begin
            wr_data_next  = ready1 ? req.req1_data : req.req0_data;
            grant_id_next = ready1;
            prio_next     = ~ready1;
        end
        if (contention && (conflict_cnt_reg != {CNT_W{1'b1}})) begin
            conflict_cnt_next = conflict_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_reg        <= '0;
            wr_data_reg      <= '0;
            grant_id_reg     <= 1'b0;
            prio_reg         <= 1'b0;
            conflict_cnt_reg <= '0;
        end else begin
            wr_en_reg        <= wr_en_next;
            wr_data_reg      <= wr_data_next;
            grant_id_reg     <= grant_id_next;
            prio_reg         <= prio_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

    assign wr_en        = wr_en_reg;
    assign wr_data      = wr_data_reg;
    assign grant_id     = grant_id_reg;
    assign conflict_cnt = conflict_cnt_reg;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter against a behavioural
// model of the arbitration rules and a register-file contents model.
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] wr_en;
    logic [63:0] wr_data;
    logic        grant_id;
    logic [7:0]  conflict_cnt;

    regfile_wr_arbiter_if #(.WIDTH(64), .ADDR_W(5)) bus ();

    regfile_wr_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .req          (bus.slave),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .grant_id     (grant_id),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int          m_prio = 0;
    int          m_cnt = 0;
    logic [31:0] m_wr_en = '0;
    logic [63:0] m_wr_data = '0;
    int          m_gid = 0;
    int          last_win = -1;
    int          wait0 = 0, wait1 = 0;
    logic [63:0] rf_exp [32];
    logic [63:0] rf_obs [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        if (!reset || stall) return -1;
        if (bus.req0_valid && bus.req1_valid) return m_prio;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    task automatic set0(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
    endtask

    task automatic set1(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
    endtask

    task automatic step();
        int          win;
        logic [4:0]  a;
        logic [63:0] d;
        #2;
        win = winner();
        chk("req0_ready", 64'(bus.req0_ready), 64'(win == 0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(win == 1));
        if (!reset) begin
            wait0 = 0; wait1 = 0;
        end else if (!stall) begin
            if (bus.req0_valid) begin
                wait0 = bus.req0_ready ? 0 : wait0 + 1;
                chk("starve0", 64'(wait0 <= 1), 64'd1);
            end
            if (bus.req1_valid) begin
                wait1 = bus.req1_ready ? 0 : wait1 + 1;
                chk("starve1", 64'(wait1 <= 1), 64'd1);
            end
        end
        @(posedge clk);
        last_win = win;
        if (!reset) begin
            m_prio = 0; m_cnt = 0; m_wr_en = '0; m_wr_data = '0; m_gid = 0;
        end else begin
            if (!stall && bus.req0_valid && bus.req1_valid && m_cnt < 255) m_cnt++;
            m_wr_en = '0;
            if (win >= 0) begin
                a = (win == 1) ? bus.req1_addr : bus.req0_addr;
                d = (win == 1) ? bus.req1_data : bus.req0_data;
                if (a != 5'd31) begin
                    m_wr_en = 32'd1 << a;
                    rf_exp[a] = d;
                end
                m_wr_data = d;
                m_gid = win;
                m_prio = 1 - win;
            end
        end
        #1;
        chk("wr_en", 64'(wr_en), 64'(m_wr_en));
        chk("wr_data", wr_data, m_wr_data);
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        for (int i = 0; i < 32; i++) if (wr_en[i]) rf_obs[i] = wr_data;
    endtask

    // Requesters keep valid/addr/data until accepted, then optionally issue anew.
    task automatic renew(input int keep_busy);
        if (last_win == 0 || !bus.req0_valid) begin
            if (keep_busy != 0 || $urandom_range(0, 3) != 0)
                set0(1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            else
                set0(1'b0, '0, '0);
        end
        if (last_win == 1 || !bus.req1_valid) begin
            if (keep_busy != 0 || $urandom_range(0, 3) != 0)
                set1(1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            else
                set1(1'b0, '0, '0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_exp[i] = '0; rf_obs[i] = '0;
        end
        set0(1'b0, '0, '0);
        set1(1'b0, '0, '0);
        step();
        step();
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_cnt", 64'(conflict_cnt), 64'd0);
        reset = 1'b1;
        step();

        // Single write from requester 0
        set0(1'b1, 5'd5, 64'hDEAD_BEEF);
        step();
        chk("single_wr_en", 64'(wr_en), 64'h20);
        chk("single_wr_data", wr_data, 64'hDEAD_BEEF);
        chk("single_gid", 64'(grant_id), 64'd0);
        set0(1'b0, '0, '0);
        step();
        chk("single_wr_en_drop", 64'(wr_en), 64'd0);

        // Write to the zero register is accepted without an enable
        set1(1'b1, 5'd31, 64'h1234);
        step();
        chk("zero_wr_en", 64'(wr_en), 64'd0);
        chk("zero_wr_data", wr_data, 64'h1234);
        chk("zero_gid", 64'(grant_id), 64'd1);
        set1(1'b0, '0, '0);
        step();

        // Tie from prio=0
        set0(1'b1, 5'd3, 64'h33);
        set1(1'b1, 5'd4, 64'h44);
        step();
        chk("tie_first", 64'(wr_en), 64'h8);
        set0(1'b0, '0, '0);
        step();
        chk("tie_second", 64'(wr_en), 64'h10);
        chk("tie_cnt", 64'(conflict_cnt), 64'd1);
        set1(1'b0, '0, '0);

        // Stall with both requesters waiting
        set0(1'b1, 5'd7, 64'h77);
        set1(1'b1, 5'd8, 64'h88);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_wr_en", 64'(wr_en), 64'd0);
            chk("stall_cnt", 64'(conflict_cnt), 64'd1);
        end
        stall = 1'b0;
        step();
        chk("stall_release_gid", 64'(grant_id), 64'd0);

        // Saturation: both valid continuously
        for (int i = 0; i < 300; i++) begin
            renew(1);
            step();
        end
        chk("sat_cnt", 64'(conflict_cnt), 64'd255);
        renew(1);
        step();
        chk("sat_hold", 64'(conflict_cnt), 64'd255);

        // Mid-operation reset with both requesters pending
        renew(1);
        reset = 1'b0;
        step();
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
        reset = 1'b1;
        step();
        chk("midrst_first_gid", 64'(grant_id), 64'd0);

        // Randomized traffic with stalls and occasional resets
        for (int i = 0; i < 600; i++) begin
            renew(0);
            stall = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) != 0);
            step();
        end
        reset = 1'b1;
        stall = 1'b0;
        set0(1'b0, '0, '0);
        set1(1'b0, '0, '0);
        step();
        for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), rf_obs[i], rf_exp[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
